wbu_idle_intvec: RTL and testbench

Output-stage inserter for the wishbone-to-UART debug bus return path, placed between the bus-executor result FIFO and the word packer. Passes result codewords through and inserts idle, bus-busy and interrupt codewords when the result stream is quiet. It handles NINT independent interrupt lines and reports which lines fired in a vectored interrupt word. Backpressure is honoured upstream, so no result word is ever dropped.

---
 rtl/wbu_idle_intvec.sv | 136 +++++++++++++
 tb/tb_wbu_idle_intvec.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbu_idle_intvec.sv
// Debug-bus return path inserter: passes result words, adds interrupt/idle/busy words in quiet slots.
// Latency 1 cycle, 1 word/cycle; o_busy stalls upstream while the output is held (never drops a word).
// Optional WBU_IDLE_INTVEC_STARVE_EN: force an interrupt word after 15 result words while one is pending.
module wbu_idle_intvec #(
    parameter int NINT     = 4,
    parameter int IDLEBITS = 31
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_stb,
    input  logic [35:0]     i_codword,
    output logic            o_busy,
    input  logic            i_cyc,
    input  logic            i_busy,
    input  logic [NINT-1:0] i_int,
    output logic            o_stb,
    output logic [35:0]     o_codword,
    input  logic            i_tx_busy
);
    localparam logic [5:0]          INT_TAG   = 6'h04;
    localparam logic [IDLEBITS-1:0] TIMER_ONE = 1;

    // What the output register currently holds.
    typedef enum logic [1:0] {K_NONE, K_PASS, K_INT, K_IDLE} kind_t;

    kind_t               kind, nxt_kind;
    logic                nxt_stb;
    logic [35:0]         nxt_word;
    logic [NINT-1:0]     pending, armed, rise, clr;
    logic [IDLEBITS-1:0] idle_timer;
    logic                rest, idle_expired, accept, out_taken, starve;
    logic [35:0]         int_word, idle_word;

    assign accept       = !o_stb || !i_tx_busy;
    assign out_taken    = o_stb && !i_tx_busy;
    assign rise         = i_int & ~armed;
    assign clr          = (out_taken && (o_codword[35:30] == INT_TAG)) ? o_codword[NINT-1:0] : '0;
    assign idle_expired = !rest && idle_timer[IDLEBITS-1];
    assign idle_word    = {(i_cyc ? 6'h01 : 6'h00), 30'h0};
    assign o_busy       = (o_stb && i_tx_busy) || starve;

    always_comb begin
        int_word             = '0;
        int_word[35:30]      = INT_TAG;
        int_word[NINT-1:0]   = pending;
    end

`ifdef WBU_IDLE_INTVEC_STARVE_EN
    logic [3:0] starve_cnt;

    assign starve = (starve_cnt == 4'hf) && (|pending);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            starve_cnt <= 4'd0;
        else if ((accept && nxt_kind == K_INT) || (out_taken && kind == K_INT) || !(|pending))
            starve_cnt <= 4'd0;
        else if (i_stb && !o_busy && starve_cnt != 4'hf)
            starve_cnt <= starve_cnt + 4'd1;
    end
`else
    assign starve = 1'b0;
`endif

    // Inserted words only go into a slot that follows an empty one.
    always_comb begin
        nxt_kind = kind;
        nxt_stb  = o_stb;
        nxt_word = o_codword;
        if (accept) begin
            if (starve) begin
                nxt_kind = K_INT;
                nxt_stb  = 1'b1;
                nxt_word = int_word;
            end else if (i_stb) begin
                nxt_kind = K_PASS;
                nxt_stb  = 1'b1;
                nxt_word = i_codword;
            end else if (!o_stb && (|pending)) begin
                nxt_kind = K_INT;
                nxt_stb  = 1'b1;
                nxt_word = int_word;
            end else if (!o_stb && idle_expired) begin
                nxt_kind = K_IDLE;
                nxt_stb  = 1'b1;
                nxt_word = idle_word;
            end else begin
                nxt_kind = K_NONE;
                nxt_stb  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            kind      <= K_NONE;
            o_stb     <= 1'b0;
            o_codword <= '0;
        end else begin
            kind      <= nxt_kind;
            o_stb     <= nxt_stb;
            o_codword <= nxt_word;
        end
    end

    // Set wins over clear when a new edge arrives as the old one is reported.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            armed   <= '0;
            pending <= '0;
        end else begin
            armed   <= i_int;
            pending <= (pending & ~clr) | rise;
        end
    end

    // The idle word itself is not activity, so a quiet period yields only one.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            idle_timer <= '0;
        else if (i_stb || i_busy || (o_stb && kind != K_IDLE))
            idle_timer <= '0;
        else if (!idle_timer[IDLEBITS-1])
            idle_timer <= idle_timer + TIMER_ONE;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            rest <= 1'b1;
        else if (out_taken && kind == K_IDLE)
            rest <= 1'b1;
        else if (!idle_timer[IDLEBITS-1])
            rest <= 1'b0;
    end

endmodule

// File: tb/tb_wbu_idle_intvec.sv
// Directed bench for wbu_idle_intvec (NINT=4, IDLEBITS=8); scenario tasks with inline checks.
module tb_wbu_idle_intvec;
    localparam int NINT     = 4;
    localparam int IDLEBITS = 8;

    logic            i_clk = 1'b0;
    logic            i_reset_n = 1'b1;
    logic            i_stb = 1'b0;
    logic [35:0]     i_codword = '0;
    logic            o_busy;
    logic            i_cyc = 1'b0;
    logic            i_busy = 1'b1;
    logic [NINT-1:0] i_int = '0;
    logic            o_stb;
    logic [35:0]     o_codword;
    logic            i_tx_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    wbu_idle_intvec #(.NINT(NINT), .IDLEBITS(IDLEBITS)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stb(i_stb), .i_codword(i_codword),
        .o_busy(o_busy), .i_cyc(i_cyc), .i_busy(i_busy), .i_int(i_int),
        .o_stb(o_stb), .o_codword(o_codword), .i_tx_busy(i_tx_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic test_reset();
        #1 i_reset_n = 1'b0;
        #1;
        checks++;
        if (o_stb !== 1'b0 || o_codword !== 36'h0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: stb=%b word=%h busy=%b, required 0/0/0", o_stb, o_codword, o_busy);
        end
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if (o_stb !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: stb=%b, required 0", o_stb);
        end
        @(negedge i_clk);
    endtask

    task automatic test_passthrough();
        logic [35:0] base;
        base = 36'h1_2345_6789;
        for (int k = 0; k < 3; k++) begin
            i_stb = 1'b1;
            i_codword = base + 36'(k);
            #1;
            checks++;
            if (o_busy !== 1'b0) begin
                errors++;
                $display("FAIL pass_busy[%0d]: busy=%b, required 0", k, o_busy);
            end
            @(posedge i_clk); #1;
            checks++;
            if (o_stb !== 1'b1 || o_codword !== base + 36'(k)) begin
                errors++;
                $display("FAIL pass_word[%0d]: stb=%b word=%h, required 1 %h", k, o_stb, o_codword, base + 36'(k));
            end
            @(negedge i_clk);
        end
        i_stb = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if (o_stb !== 1'b0) begin
            errors++;
            $display("FAIL pass_drain: stb=%b, required 0", o_stb);
        end
        @(negedge i_clk);
    endtask

    task automatic test_backpressure();
        i_stb = 1'b1;
        i_codword = 36'hA_AAAA_0001;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        i_codword = 36'hB_BBBB_0002;
        i_tx_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (o_busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_busy[%0d]: busy=%b, required 1", k, o_busy);
            end
            @(posedge i_clk); #1;
            checks++;
            if (o_stb !== 1'b1 || o_codword !== 36'hA_AAAA_0001) begin
                errors++;
                $display("FAIL hold_word[%0d]: stb=%b word=%h, required 1 aaaaa0001", k, o_stb, o_codword);
            end
            @(negedge i_clk);
        end
        i_tx_busy = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release_busy: busy=%b, required 0", o_busy);
        end
        @(posedge i_clk); #1;
        checks++;
        if (o_stb !== 1'b1 || o_codword !== 36'hB_BBBB_0002) begin
            errors++;
            $display("FAIL hold_release_word: stb=%b word=%h, required 1 bbbbb0002", o_stb, o_codword);
        end
        @(negedge i_clk);
        i_stb = 1'b0;
        @(posedge i_clk); #1;
        @(negedge i_clk);
    endtask

    task automatic test_reset_mid_hold();
        i_stb = 1'b1;
        i_codword = 36'hC_0000_00CC;
        i_tx_busy = 1'b1;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        i_stb = 1'b0;
        i_int = 4'b0010;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        i_int = 4'b0000;
        #2 i_reset_n = 1'b0;
        #1;
        checks++;
        if (o_stb !== 1'b0 || o_codword !== 36'h0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: stb=%b word=%h busy=%b, required 0/0/0", o_stb, o_codword, o_busy);
        end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        i_tx_busy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            checks++;
            if (o_stb !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_word[%0d]: stb=%b word=%h, required stb 0", k, o_stb, o_codword);
            end
        end
        @(negedge i_clk);
    endtask

    task automatic test_interrupt();
        i_int = 4'b0101;
        @(posedge i_clk); #1;
        checks++;
        if (o_stb !== 1'b0) begin
            errors++;
            $display("FAIL int_bubble: stb=%b, required 0", o_stb);
        end
        @(negedge i_clk);
        i_int = 4'b0100;
        @(posedge i_clk); #1;
        checks++;
        if (o_stb !== 1'b1 || o_codword !== 36'h1_0000_0005) begin
            errors++;
            $display("FAIL int_word: stb=%b word=%h, required 1 100000005", o_stb, o_codword);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            checks++;
            if (o_stb !== 1'b0) begin
                errors++;
                $display("FAIL int_no_repeat[%0d]: stb=%b word=%h, required stb 0", k, o_stb, o_codword);
            end
        end
        @(negedge i_clk);
        i_int = 4'b0000;
        @(negedge i_clk);
    endtask

    task automatic test_starve();
        logic [35:0] base;
        int idx;
        logic exp_busy;
        logic [35:0] exp_word;
        logic exp_tail;
        base = 36'h5_0000_0000;
        idx = 0;
        for (int c = 0; c < 22; c++) begin
            i_stb = 1'b1;
            i_codword = base + 36'(idx);
            i_int = (c >= 1) ? 4'b0010 : 4'b0000;
`ifdef WBU_IDLE_INTVEC_STARVE_EN
            exp_busy = (c == 17);
`else
            exp_busy = 1'b0;
`endif
            #1;
            checks++;
            if (o_busy !== exp_busy) begin
                errors++;
                $display("FAIL starve_busy[%0d]: busy=%b, required %b", c, o_busy, exp_busy);
            end
            @(posedge i_clk); #1;
            exp_word = exp_busy ? 36'h1_0000_0002 : base + 36'(idx);
            checks++;
            if (o_stb !== 1'b1 || o_codword !== exp_word) begin
                errors++;
                $display("FAIL starve_word[%0d]: stb=%b word=%h, required 1 %h", c, o_stb, o_codword, exp_word);
            end
            if (!exp_busy) idx++;
            @(negedge i_clk);
        end
        i_stb = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if (o_stb !== 1'b0) begin
            errors++;
            $display("FAIL starve_drain: stb=%b, required 0", o_stb);
        end
`ifdef WBU_IDLE_INTVEC_STARVE_EN
        exp_tail = 1'b0;
`else
        exp_tail = 1'b1;
`endif
        @(posedge i_clk); #1;
        checks++;
        if (o_stb !== exp_tail || (exp_tail && o_codword !== 36'h1_0000_0002)) begin
            errors++;
            $display("FAIL starve_tail: stb=%b word=%h, required stb %b (word 100000002 if 1)", o_stb, o_codword, exp_tail);
        end
        @(negedge i_clk);
        i_int = 4'b0000;
        @(posedge i_clk); #1;
        @(negedge i_clk);
    endtask

    task automatic test_idle();
        int n;
        int extra;
        i_busy = 1'b0;
        i_cyc = 1'b1;
        i_reset_n = 1'b0;
        #2 i_reset_n = 1'b1;
        n = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge i_clk); #1;
            n++;
            if (o_stb) break;
        end
        checks++;
        if (n !== 129 || o_stb !== 1'b1 || o_codword !== 36'h0_4000_0000) begin
            errors++;
            $display("FAIL idle_busy_word: after %0d cycles stb=%b word=%h, required 129 cycles 1 040000000", n, o_stb, o_codword);
        end
        extra = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge i_clk); #1;
            if (o_stb) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL idle_once: %0d extra words, required 0", extra);
        end
        @(negedge i_clk);
        i_cyc = 1'b0;
        i_stb = 1'b1;
        i_codword = 36'h7_0000_0077;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        i_stb = 1'b0;
        n = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge i_clk); #1;
            n++;
            if (o_stb) break;
        end
        checks++;
        if (n !== 130 || o_stb !== 1'b1 || o_codword !== 36'h0) begin
            errors++;
            $display("FAIL idle_rearm: after %0d cycles stb=%b word=%h, required 130 cycles 1 000000000", n, o_stb, o_codword);
        end
        @(negedge i_clk);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_backpressure();
        test_reset_mid_hold();
        test_interrupt();
        test_starve();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
